// File: rtl/icache_ctrl.sv
// icache_ctrl: control stage of the 2-way, 256-set, 16-byte-line instruction cache.
// Latency: hit gives insn_valid 1 cycle after acceptance; miss takes 2 cycles + memory latency + 1.
// Backpressure: accepts in IDLE or on a hit; miss_stall holds fetch off and if_req is ignored until the refill cycle.
// Ports:
//   fetch side : if_req/if_addr in; insn/insn_valid/miss_stall out
//   RAM side   : index, block0/1_re, block0/1_we, data_wd, tag_wd out; data0/1_rd, tag0/1_rd in (1-cycle read)
//   memory side: mem_req/mem_addr out (held until mem_rdy); mem_rdy/mem_line in
module icache_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [31:0]  if_addr,
  output logic [31:0]  insn,
  output logic         insn_valid,
  output logic         miss_stall,
  output logic [7:0]   index,
  output logic         block0_re,
  output logic         block1_re,
  output logic         block0_we,
  output logic         block1_we,
  output logic [127:0] data_wd,
  input  logic [127:0] data0_rd,
  input  logic [127:0] data1_rd,
  output logic [19:0]  tag_wd,
  input  logic [19:0]  tag0_rd,
  input  logic [19:0]  tag1_rd,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_rdy,
  input  logic [127:0] mem_line
);

  typedef enum logic [1:0] {IDLE, ACCESS, MISS, REFILL} state_e;

  state_e       state_q, state_d;
  // Byte-within-word bits are never used, so only the word address is kept.
  logic [31:2]  addr_q, addr_d;
  logic [127:0] line_q, line_d;
  logic [255:0] valid0_q, valid1_q;
  // lru_q[i] names the way to replace next in set i.
  logic [255:0] lru_q;

  logic [19:0]  req_tag;
  logic [7:0]   req_idx;
  logic [1:0]   req_off;
  logic         hit0, hit1, hit, victim;
  logic         val0_set, val1_set, lru_we, lru_wd;
  logic         unused_byte_bits;

  assign unused_byte_bits = ^if_addr[1:0];

  assign req_tag = addr_q[31:12];
  assign req_idx = addr_q[11:4];
  assign req_off = addr_q[3:2];

  assign hit0 = valid0_q[req_idx] && (tag0_rd == req_tag);
  assign hit1 = valid1_q[req_idx] && (tag1_rd == req_tag);
  assign hit  = hit0 || hit1;

  // Fill an empty way first (way0 before way1); only evict by LRU when the set is full.
  assign victim = !valid0_q[req_idx] ? 1'b0 :
                  !valid1_q[req_idx] ? 1'b1 : lru_q[req_idx];

  function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] off);
    return line[{off, 5'd0} +: 32];
  endfunction

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    line_d     = line_q;
    insn       = '0;
    insn_valid = 1'b0;
    miss_stall = 1'b0;
    index      = '0;
    block0_re  = 1'b0;
    block1_re  = 1'b0;
    block0_we  = 1'b0;
    block1_we  = 1'b0;
    data_wd    = '0;
    tag_wd     = '0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    val0_set   = 1'b0;
    val1_set   = 1'b0;
    lru_we     = 1'b0;
    lru_wd     = 1'b0;

    // Outputs stay quiet during reset so nothing leaks to the RAMs or memory.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (if_req) begin
            addr_d    = if_addr[31:2];
            index     = if_addr[11:4];
            block0_re = 1'b1;
            block1_re = 1'b1;
            state_d   = ACCESS;
          end
        end

        ACCESS: begin
          if (hit) begin
            insn_valid = 1'b1;
            // way0 wins when both ways match
            insn       = word_sel(hit0 ? data0_rd : data1_rd, req_off);
            lru_we     = 1'b1;
            lru_wd     = hit0;
            if (if_req) begin
              // Overlap the next lookup with this hit for 1-per-cycle throughput.
              addr_d    = if_addr[31:2];
              index     = if_addr[11:4];
              block0_re = 1'b1;
              block1_re = 1'b1;
              state_d   = ACCESS;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = MISS;
          end
        end

        MISS: begin
          miss_stall = 1'b1;
          mem_req    = 1'b1;
          mem_addr   = {addr_q[31:4], 4'b0000};
          if (mem_rdy) begin
            line_d  = mem_line;
            state_d = REFILL;
          end
        end

        REFILL: begin
          block0_we  = ~victim;
          block1_we  = victim;
          data_wd    = line_q;
          tag_wd     = req_tag;
          index      = req_idx;
          val0_set   = ~victim;
          val1_set   = victim;
          lru_we     = 1'b1;
          lru_wd     = ~victim;
          insn_valid = 1'b1;
          insn       = word_sel(line_q, req_off);
          state_d    = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      line_q   <= '0;
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      // req_idx still refers to the completing request even when a new one is latched this edge.
      if (val0_set) valid0_q[req_idx] <= 1'b1;
      if (val1_set) valid1_q[req_idx] <= 1'b1;
      if (lru_we)   lru_q[req_idx]    <= lru_wd;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed table, reset-mid-miss sequence and randomized traffic for icache_ctrl.
// Tag/data RAMs and backing memory are modelled here; expectations come from a set-level cache model.
module tb_icache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         if_req;
  logic [31:0]  if_addr;
  logic [31:0]  insn;
  logic         insn_valid;
  logic         miss_stall;
  logic [7:0]   index;
  logic         block0_re, block1_re, block0_we, block1_we;
  logic [127:0] data_wd;
  logic [127:0] data0_rd = '0;
  logic [127:0] data1_rd = '0;
  logic [19:0]  tag_wd;
  logic [19:0]  tag0_rd = '0;
  logic [19:0]  tag1_rd = '0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_rdy;
  logic [127:0] mem_line;

  icache_ctrl dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .insn(insn), .insn_valid(insn_valid), .miss_stall(miss_stall), .index(index),
    .block0_re(block0_re), .block1_re(block1_re), .block0_we(block0_we), .block1_we(block1_we),
    .data_wd(data_wd), .data0_rd(data0_rd), .data1_rd(data1_rd),
    .tag_wd(tag_wd), .tag0_rd(tag0_rd), .tag1_rd(tag1_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_line(mem_line)
  );

  always #5 clk = ~clk;

  // Storage arrays: synchronous write, registered read.
  logic [19:0]  tram0 [256] = '{default: '0};
  logic [19:0]  tram1 [256] = '{default: '0};
  logic [127:0] dram0 [256] = '{default: '0};
  logic [127:0] dram1 [256] = '{default: '0};

  always @(posedge clk) begin
    if (block0_we) begin tram0[index] <= tag_wd; dram0[index] <= data_wd; end
    if (block1_we) begin tram1[index] <= tag_wd; dram1[index] <= data_wd; end
    if (block0_re) begin tag0_rd <= tram0[index]; data0_rd <= dram0[index]; end
    if (block1_re) begin tag1_rd <= tram1[index]; data1_rd <= dram1[index]; end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Backing memory: each word is a distinct odd-multiplier hash of its word address.
  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++)
      l[w*32 +: 32] = ({a[31:4], 4'b0000} | (w << 2)) * 32'h9E37_79B1;
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [127:0] l;
    l = line_of(a);
    return l[a[3:2]*32 +: 32];
  endfunction

  // Reference cache model: per-set contents of each way plus the way to replace next.
  bit          mv0 [256];
  bit          mv1 [256];
  logic [19:0] mt0 [256];
  logic [19:0] mt1 [256];
  bit          ml  [256];

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      mv0[i] = 0; mv1[i] = 0; mt0[i] = '0; mt1[i] = '0; ml[i] = 0;
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return (mv0[a[11:4]] && mt0[a[11:4]] == a[31:12]) || (mv1[a[11:4]] && mt1[a[11:4]] == a[31:12]);
  endfunction

  function automatic bit model_victim(input logic [31:0] a);
    int i;
    i = a[11:4];
    if (!mv0[i]) return 1'b0;
    if (!mv1[i]) return 1'b1;
    return ml[i];
  endfunction

  task automatic model_update(input logic [31:0] a);
    int i;
    bit v;
    i = a[11:4];
    if (mv0[i] && mt0[i] == a[31:12])      ml[i] = 1;
    else if (mv1[i] && mt1[i] == a[31:12]) ml[i] = 0;
    else begin
      v = model_victim(a);
      if (v) begin mv1[i] = 1; mt1[i] = a[31:12]; end
      else   begin mv0[i] = 1; mt0[i] = a[31:12]; end
      ml[i] = ~v;
    end
  endtask

  bit          pend_vld = 0;
  logic [31:0] pend_addr = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pending();
    if (pend_vld) begin
      chk("hit_valid", insn_valid, 1'b1);
      chk("hit_insn", insn, word_of(pend_addr));
      chk("hit_no_memreq", mem_req, 1'b0);
    end else begin
      chk("no_stray_valid", insn_valid, 1'b0);
    end
  endtask

  // Entry: just after a posedge, DUT ready to accept (IDLE, or ACCESS completing a hit).
  task automatic run_txn(input logic [31:0] a, input bit ehit, input bit eway, input bit chain);
    int lat;
    if_req = 1'b1; if_addr = a; mem_rdy = 1'b0;
    @(negedge clk);
    check_pending();
    chk("accept_re", {block0_re, block1_re}, 2'b11);
    chk("accept_idx", index, a[11:4]);
    chk("accept_stall", miss_stall, 1'b0);
    step();
    pend_vld = 0;
    model_update(a);
    if (ehit) begin
      pend_vld  = 1;
      pend_addr = a;
      if (!chain) begin
        if_req = 1'b0; if_addr = $urandom;
        @(negedge clk);
        check_pending();
        pend_vld = 0;
        step();
      end
    end else begin
      if_req = 1'($urandom); if_addr = $urandom;
      @(negedge clk);
      chk("lookup_miss_valid", insn_valid, 1'b0);
      chk("lookup_miss_re", {block0_re, block1_re}, 2'b00);
      step();
      lat = $urandom_range(0, 3);
      for (int k = 0; k < lat; k++) begin
        if_req = 1'($urandom); if_addr = $urandom;
        @(negedge clk);
        chk("miss_memreq", mem_req, 1'b1);
        chk("miss_memaddr", mem_addr, {a[31:4], 4'b0000});
        chk("miss_stall", miss_stall, 1'b1);
        chk("miss_no_rw", {block0_re, block1_re, block0_we, block1_we}, 4'b0000);
        step();
      end
      mem_rdy = 1'b1; mem_line = line_of(a); if_req = 1'($urandom); if_addr = $urandom;
      @(negedge clk);
      chk("rdy_memreq", mem_req, 1'b1);
      chk("rdy_memaddr", mem_addr, {a[31:4], 4'b0000});
      step();
      mem_rdy = 1'b0; mem_line = {$urandom, $urandom, $urandom, $urandom};
      if_req = 1'($urandom); if_addr = $urandom;
      @(negedge clk);
      chk("refill_we", {block1_we, block0_we}, eway ? 2'b10 : 2'b01);
      chk("refill_re", {block0_re, block1_re}, 2'b00);
      chk("refill_idx", index, a[11:4]);
      chk("refill_tag", tag_wd, a[31:12]);
      chk("refill_data", data_wd, line_of(a));
      chk("refill_valid", insn_valid, 1'b1);
      chk("refill_insn", insn, word_of(a));
      chk("refill_stall", miss_stall, 1'b0);
      chk("refill_memreq", mem_req, 1'b0);
      step();
      if_req = 1'b0;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          ehit;
    bit          eway;
    bit          chain;
  } vec_t;

  vec_t       tbl [11];
  logic [7:0] idx_tab [4] = '{8'h23, 8'h00, 8'hFF, 8'h80};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] a;
    logic [19:0] tg;
    bit          ch;

    tbl[0]  = '{32'h0000_1234, 1'b0, 1'b0, 1'b0}; // cold miss into way0
    tbl[1]  = '{32'h0000_123C, 1'b1, 1'b0, 1'b0}; // hit after fill
    tbl[2]  = '{32'h0000_2230, 1'b0, 1'b1, 1'b0}; // second line into empty way1
    tbl[3]  = '{32'h0000_1230, 1'b1, 1'b0, 1'b0}; // touch way0, way1 becomes LRU
    tbl[4]  = '{32'h0000_3230, 1'b0, 1'b1, 1'b0}; // conflict evicts way1
    tbl[5]  = '{32'h0000_1234, 1'b1, 1'b0, 1'b0}; // way0 retained
    tbl[6]  = '{32'h0000_1230, 1'b1, 1'b0, 1'b1}; // four back-to-back hits
    tbl[7]  = '{32'h0000_1238, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{32'h0000_3234, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{32'h0000_123C, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{32'h0000_2230, 1'b0, 1'b1, 1'b0}; // way0 most recent -> evict way1

    model_reset();
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h0000_1234; mem_rdy = 1'b1; mem_line = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_insn", insn, 32'h0);
    chk("rst_valid", insn_valid, 1'b0);
    chk("rst_stall", miss_stall, 1'b0);
    chk("rst_index", index, 8'h0);
    chk("rst_en", {block0_re, block1_re, block0_we, block1_we}, 4'b0000);
    chk("rst_memreq", mem_req, 1'b0);
    chk("rst_memaddr", mem_addr, 32'h0);
    chk("rst_wd", data_wd, 128'h0);
    chk("rst_tagwd", tag_wd, 20'h0);
    step();
    rst = 1'b0; if_req = 1'b0; mem_rdy = 1'b0; mem_line = '0;

    for (int i = 0; i < 11; i++)
      run_txn(tbl[i].addr, tbl[i].ehit, tbl[i].eway, tbl[i].chain);

    // Reset while a miss is outstanding.
    if_req = 1'b1; if_addr = 32'h0000_4234;
    @(negedge clk);
    step();
    if_req = 1'b0;
    @(negedge clk);
    chk("rmm_lookup_miss", insn_valid, 1'b0);
    step();
    @(negedge clk);
    chk("rmm_memreq_before", mem_req, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_rdy = 1'b1; mem_line = line_of(32'h0000_4234);
    @(negedge clk);
    chk("rmm_memreq_after", mem_req, 1'b0);
    chk("rmm_stall_after", miss_stall, 1'b0);
    chk("rmm_no_we", {block0_we, block1_we}, 2'b00);
    step();
    mem_rdy = 1'b0;
    @(negedge clk);
    chk("rmm_no_we_late", {block0_we, block1_we}, 2'b00);
    chk("rmm_no_valid", insn_valid, 1'b0);
    step();
    model_reset();
    pend_vld = 0;
    run_txn(32'h0000_4234, 1'b0, 1'b0, 1'b0);
    run_txn(32'h0000_1234, 1'b0, 1'b1, 1'b0); // was valid before reset, must miss again

    // Randomized traffic against the set-level model.
    for (int n = 0; n < 300; n++) begin
      tg = 20'($urandom_range(1, 4));
      a  = {tg, idx_tab[$urandom_range(0, 3)], 2'($urandom), 2'b00};
      ch = ($urandom_range(0, 1) == 1) && (n < 299);
      run_txn(a, model_hit(a), model_victim(a), ch);
    end
    if (pend_vld) begin
      if_req = 1'b0;
      @(negedge clk);
      check_pending();
      pend_vld = 0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Control stage of the 2-way, 256-set, 16-byte-line instruction cache.
- Sits between the fetch stage and the cache storage arrays.
- Drives index, read enables and write enables for the data RAM and tag RAM, and compares tags.
- Selects the fetched word, handles misses by requesting a full line from the memory side, and keeps valid and LRU state.
- Address split: tag = addr[31:12], index = addr[11:4], word offset = addr[3:2].

Parameters:
- None. Geometry is fixed: 2 ways, 256 sets, 128-bit line, 20-bit tag.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request
if_addr  in  32  fetch byte address
insn  out  32  fetched instruction
insn_valid  out  1  insn valid, one-cycle pulse per request
miss_stall  out  1  high while a miss is in progress
index  out  8  set index to data/tag RAMs
block0_re  out  1  way0 data/tag read enable
block1_re  out  1  way1 data/tag read enable
block0_we  out  1  way0 data/tag write enable
block1_we  out  1  way1 data/tag write enable
data_wd  out  128  line write data
data0_rd  in  128  way0 line, valid 1 cycle after read enable
data1_rd  in  128  way1 line, valid 1 cycle after read enable
tag_wd  out  20  tag write data
tag0_rd  in  20  way0 tag, valid 1 cycle after read enable
tag1_rd  in  20  way1 tag, valid 1 cycle after read enable
mem_req  out  1  line fill request, held until mem_rdy
mem_addr  out  32  line-aligned fill address {tag, index, 4'b0}
mem_rdy  in  1  fill data valid, single-cycle pulse
mem_line  in  128  fill data

Behaviour:
- Internal state:
  - valid[2][256]: cleared by rst.
  - lru[256]: each bit holds the way to replace next; cleared by rst.
  - addr_q: latched request address.
- States: IDLE, ACCESS, MISS, REFILL.
- Reset:
  - state goes to IDLE.
  - All outputs are 0: insn, insn_valid, miss_stall, enables, mem_req, mem_addr, data_wd, tag_wd, index.
  - Reset mid-miss: mem_req drops on the next edge, no RAM write occurs, and any later mem_rdy is ignored.
- IDLE:
  - When if_req=1: latch addr_q, drive index=if_addr[11:4], assert block0_re=block1_re=1, then go to ACCESS.
- ACCESS:
  - Compare tagN_rd == addr_q tag with valid[N][index] per way.
  - Hit: insn_valid=1; insn = the hit way's line word at offset (offset 0 = bits [31:0], offset 3 = bits [127:96]); lru[index] is set to the other way.
  - If both ways match, way0 wins.
  - Hit with if_req=1: accept the next request in the same cycle (latch, read, stay in ACCESS). This gives back-to-back throughput of 1 per cycle.
  - Hit with if_req=0: go to IDLE.
  - Miss: go to MISS; insn_valid=0.
- MISS:
  - miss_stall=1, mem_req=1, mem_addr={addr_q[31:4],4'b0}.
  - On mem_rdy=1, go to REFILL and capture mem_line.
  - if_req is ignored in MISS and REFILL.
- REFILL (one cycle):
  - Victim selection: way0 if invalid, else way1 if invalid, else lru[index].
  - Assert the victim's blockN_we, with data_wd=line, tag_wd=addr_q tag, index=addr_q index.
  - Set valid[victim]=1 and lru[index]=~victim.
  - insn_valid=1, with insn taken from the captured line at addr_q offset.
  - miss_stall=0 in this cycle; go to IDLE.
- Read enables are asserted only when issuing a lookup; write enables only in REFILL. A read and a write are never asserted in the same cycle.
- Miss latency: request to insn_valid = 2 cycles + memory latency + 1.
- Hit latency: 1 cycle after acceptance.

Test Plan:
- Cold miss: rst, then if_req with addr 0x0000_1234 -> mem_req=1, mem_addr=0x0000_1230. Then mem_rdy with line {D3,D2,D1,D0} -> block0_we=1 at index 0x23, tag_wd=0x00001; insn=D1 with insn_valid=1; lru[0x23]=1.
- Hit after fill: request 0x0000_123C -> insn=D3 one cycle after acceptance, no mem_req; lru[0x23]=1.
- Back-to-back hits: if_req held across 4 addresses in filled lines -> 4 consecutive insn_valid pulses, miss_stall=0 throughout.
- Conflict and LRU: fill 0x0000_1230 into way0 and 0x0000_2230 into way1, hit 0x0000_1230, then miss on 0x0000_3230 -> block1_we=1, way0 retained.
- Reset mid-miss: rst asserted while in MISS -> mem_req=0 next cycle. A following mem_rdy causes no write. A subsequent request to the same address misses again because valid was cleared.
- Stall hold: if_req toggling while in MISS -> no new read enables, and addr_q is unchanged until REFILL.
